glitch_delay: RTL

- Consumer end of the controller's `delay`/`set_delay` interface.
- Latches the programmed delay. On a trigger event it counts that many clock cycles, then drives a fixed-width glitch pulse to the injection hardware, and finally reports completion back to the controller.
- Sits between the trigger detector and the glitch output stage.
- One trigger event produces at most one glitch.

---
 rtl/glitch_delay_if.sv | 40 ++++
 rtl/glitch_delay.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/glitch_delay_if.sv
// Controller-facing bundle for the glitch delay block: delay programming,
// trigger/abort inputs, and the readback, glitch, busy and done outputs.
// Ports: master = controller/trigger side, slave = glitch_delay itself.
interface glitch_delay_if #(
    parameter int DELAY_W = 32
);
    // Controller / trigger detector -> glitch_delay
    logic [DELAY_W-1:0] delay;      // delay value to program
    logic               set_delay;  // 1-cycle strobe, latches delay
    logic               trigger;    // trigger level; rising edge is the event
    logic               abort;      // cancels any countdown or pulse

    // glitch_delay -> controller / glitch output stage
    logic [DELAY_W-1:0] delay_q;    // currently latched delay
    logic               glitch;     // registered glitch pulse
    logic               busy;       // high while counting down or pulsing
    logic               done;       // 1-cycle strobe after a completed pulse

    modport master (
        output delay,
        output set_delay,
        output trigger,
        output abort,
        input  delay_q,
        input  glitch,
        input  busy,
        input  done
    );

    modport slave (
        input  delay,
        input  set_delay,
        input  trigger,
        input  abort,
        output delay_q,
        output glitch,
        output busy,
        output done
    );
endinterface

// File: rtl/glitch_delay.sv
// Purpose: on a trigger rising edge, wait the latched delay, emit a fixed-width glitch, then strobe done.
// Latency: glitch rises delay_q edges after the edge sampling the trigger rise, high PULSE_CYCLES cycles; done follows.
// Backpressure: none; trigger rises while busy or in DONE are dropped, abort cancels at any time.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset (drops glitch immediately)
//   bus  - glitch_delay_if.slave: delay/set_delay/trigger/abort in,
//          delay_q/glitch/busy/done out
module glitch_delay #(
    parameter int DELAY_W      = 32,
    parameter int PULSE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    glitch_delay_if.slave     bus
);

    // A zero-width pulse makes no sense and would underflow the pulse counter.
    if (PULSE_CYCLES < 1) begin : g_bad_pulse_cycles
        $error("glitch_delay: PULSE_CYCLES must be >= 1");
    end

    // The pulse counter only needs to hold PULSE_CYCLES-1; keep it at least
    // one bit wide so PULSE_CYCLES == 1 still elaborates.
    localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [DELAY_W-1:0] ONE      = DELAY_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_PULSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DELAY_W-1:0]  delay_r;
    logic [DELAY_W-1:0]  cnt_q;
    logic [DELAY_W-1:0]  cnt_d;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [PCNT_W-1:0]   pcnt_d;
    logic                glitch_q;
    logic                glitch_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                trigger_d;
    logic                trig_rise;

    // ------------------------------------------------------------------
    // Delay register: reprogrammable in any state. A running countdown
    // holds its own copy in cnt_q, so a new value only affects the next
    // trigger, including when set_delay and trig_rise share an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_r <= '0;
        end else if (bus.set_delay) begin
            delay_r <= bus.delay;
        end
    end

    // ------------------------------------------------------------------
    // Trigger edge detect. History is updated every cycle regardless of
    // state, so a trigger held high across a whole run never re-fires.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigger_d <= 1'b0;
        end else begin
            trigger_d <= bus.trigger;
        end
    end

    assign trig_rise = bus.trigger & ~trigger_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            glitch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        glitch_d = glitch_q;
        done_d   = 1'b0;

        if (bus.abort) begin
            // Abort wins over everything on the same edge; no done strobe.
            state_d  = S_IDLE;
            glitch_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (trig_rise) begin
                        if (delay_r == '0) begin
                            // Zero delay: glitch starts on the trigger edge.
                            glitch_d = 1'b1;
                            pcnt_d   = PCNT_LAST;
                            state_d  = S_PULSE;
                        end else begin
                            // The trigger edge itself is the first of the
                            // delay_r cycles, so load one less.
                            cnt_d   = delay_r - ONE;
                            state_d = S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt_q == '0) begin
                        glitch_d = 1'b1;
                        pcnt_d   = PCNT_LAST;
                        state_d  = S_PULSE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end

                S_PULSE: begin
                    if (pcnt_q == '0) begin
                        glitch_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        pcnt_d = pcnt_q - PCNT_W'(1);
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d  = S_IDLE;
                    glitch_d = 1'b0;
                end
            endcase
        end

        // busy is registered from the next state so it lines up exactly
        // with the cycles spent in WAIT or PULSE.
        busy_d = (state_d == S_WAIT) || (state_d == S_PULSE);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.delay_q = delay_r;
    assign bus.glitch  = glitch_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

`ifndef SYNTHESIS
    // glitch is only ever high while in PULSE.
    a_glitch_in_pulse: assert property (
        @(posedge clk) disable iff (rst) glitch_q |-> (state_q == S_PULSE)
    );
    // busy mirrors the WAIT/PULSE states.
    a_busy_matches_state: assert property (
        @(posedge clk) disable iff (rst)
            busy_q == ((state_q == S_WAIT) || (state_q == S_PULSE))
    );
`endif

endmodule
